// File: rtl/keypad_pkg.sv
// Shared types, key codes and operand limits for the keypad reader.
package keypad_pkg;

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_e;

    localparam int unsigned CODE_W      = 4;
    localparam int unsigned OPERAND_W   = 10;
    localparam int unsigned DIGIT_LIMIT = 3;
    localparam int unsigned DCNT_W      = 2;

    localparam logic [CODE_W-1:0] KEY_STAR = 4'hE;
    localparam logic [CODE_W-1:0] KEY_HASH = 4'hF;

    // Keypad matrix position to key code.
    function automatic logic [CODE_W-1:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        logic [CODE_W-1:0] code;
        case ({row, col})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = KEY_STAR;
            4'd13:   code = 4'h0;
            4'd14:   code = KEY_HASH;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest-index active-low row wins when several rows are pulled.
    function automatic logic [1:0] lowest_low(input logic [3:0] pat);
        logic [1:0] r;
        r = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!pat[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] sel);
        logic [1:0] c;
        case (sel)
            4'b1110: c = 2'd0;
            4'b1101: c = 2'd1;
            4'b1011: c = 2'd2;
            default: c = 2'd3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/keypad_reader_if.sv
// Key report and operand handshake between the keypad reader and its consumer.
interface keypad_reader_if;
    import keypad_pkg::*;

    logic [CODE_W-1:0]    key_code;
    logic                 key_valid;
    logic [OPERAND_W-1:0] entry_value;
    logic [OPERAND_W-1:0] number_out;
    logic                 number_valid;
    logic                 number_ready;

    modport master (
        output key_code, key_valid, entry_value, number_out, number_valid,
        input  number_ready
    );

    modport slave (
        input  key_code, key_valid, entry_value, number_out, number_valid,
        output number_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous row lines.
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ff1_q;
    logic [WIDTH-1:0] ff2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff1_q <= '0;
            ff2_q <= '0;
        end else begin
            ff1_q <= d;
            ff2_q <= ff1_q;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/keypad_reader.sv
// 4x4 keypad scanner with debounce, 3-digit decimal entry and operand commit handshake.
module keypad_reader
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      rows,
    output logic [3:0]      col_select,
    keypad_reader_if.master bus
);

    localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES + 1);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned MUL_W  = OPERAND_W + 4;

    logic [3:0] rows_s;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_s)
    );

    state_e               state_q,     state_d;
    logic [3:0]           col_sel_q,   col_sel_d;
    logic [SCAN_W-1:0]    scan_cnt_q,  scan_cnt_d;
    logic [DEB_W-1:0]     deb_cnt_q,   deb_cnt_d;
    logic [3:0]           pat_q,       pat_d;
    logic [CODE_W-1:0]    key_code_q,  key_code_d;
    logic                 key_valid_q, key_valid_d;
    logic [OPERAND_W-1:0] entry_q,     entry_d;
    logic [DCNT_W-1:0]    digit_cnt_q, digit_cnt_d;
    logic [OPERAND_W-1:0] num_q,       num_d;
    logic                 num_valid_q, num_valid_d;

    logic             scan_last;
    logic             deb_last;
    logic [3:0]       col_next;
    logic [MUL_W-1:0] entry_mul;

    assign scan_last = (scan_cnt_q == SCAN_W'(SCAN_CYCLES - 1));
    assign deb_last  = (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1));
    assign col_next  = {col_sel_q[2:0], col_sel_q[3]};
    assign entry_mul = MUL_W'(entry_q) * MUL_W'(10) + MUL_W'(key_code_q);

    // Scan / debounce / hold / release sequencing.
    always_comb begin
        state_d     = state_q;
        col_sel_d   = col_sel_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        pat_d       = pat_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        case (state_q)
            S_SCAN: begin
                if (scan_last) begin
                    scan_cnt_d = '0;
                    if (rows_s != 4'hF) begin
                        pat_d     = rows_s;
                        deb_cnt_d = '0;
                        state_d   = S_DEBOUNCE;
                    end else begin
                        col_sel_d = col_next;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            S_DEBOUNCE: begin
                if (rows_s == pat_q) begin
                    if (deb_last) begin
                        key_valid_d = 1'b1;
                        key_code_d  = key_lookup(lowest_low(pat_q), col_index(col_sel_q));
                        deb_cnt_d   = '0;
                        state_d     = S_PRESSED;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end else begin
                    col_sel_d  = col_next;
                    scan_cnt_d = '0;
                    deb_cnt_d  = '0;
                    state_d    = S_SCAN;
                end
            end
            S_PRESSED: begin
                if (rows_s == 4'hF) begin
                    deb_cnt_d = '0;
                    state_d   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (rows_s != 4'hF) begin
                    state_d = S_PRESSED;
                end else if (deb_last) begin
                    col_sel_d  = col_next;
                    scan_cnt_d = '0;
                    deb_cnt_d  = '0;
                    state_d    = S_SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: state_d = S_SCAN;
        endcase
    end

    // Digit accumulation and operand commit; the consumer handshake is
    // resolved against the pre-edge valid, so a '#' racing it is dropped.
    always_comb begin
        entry_d     = entry_q;
        digit_cnt_d = digit_cnt_q;
        num_d       = num_q;
        num_valid_d = num_valid_q;
        if (num_valid_q && bus.number_ready) begin
            num_valid_d = 1'b0;
        end
        if (key_valid_q) begin
            if (key_code_q <= 4'h9) begin
                if (digit_cnt_q < DCNT_W'(DIGIT_LIMIT)) begin
                    entry_d     = OPERAND_W'(entry_mul);
                    digit_cnt_d = digit_cnt_q + DCNT_W'(1);
                end
            end else if (key_code_q == KEY_STAR) begin
                entry_d     = '0;
                digit_cnt_d = '0;
            end else if (key_code_q == KEY_HASH) begin
                if ((digit_cnt_q != '0) && !num_valid_q) begin
                    num_d       = entry_q;
                    num_valid_d = 1'b1;
                    entry_d     = '0;
                    digit_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_SCAN;
            col_sel_q   <= 4'b1110;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            pat_q       <= 4'hF;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            entry_q     <= '0;
            digit_cnt_q <= '0;
            num_q       <= '0;
            num_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_sel_q   <= col_sel_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            pat_q       <= pat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            entry_q     <= entry_d;
            digit_cnt_q <= digit_cnt_d;
            num_q       <= num_d;
            num_valid_q <= num_valid_d;
        end
    end

    assign col_select       = col_sel_q;
    assign bus.key_code     = key_code_q;
    assign bus.key_valid    = key_valid_q;
    assign bus.entry_value  = entry_q;
    assign bus.number_out   = num_q;
    assign bus.number_valid = num_valid_q;

endmodule

// File: doc/keypad_reader.md
KEYPAD_READER -- requirements
Module: keypad_reader

Interface
REQ-001 Parameter SCAN_CYCLES, default 1000, number of clk cycles each column is driven during scanning.
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000, number of consecutive clk cycles a row pattern must be stable to count as a press or release.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rows  input  4  keypad row lines, active-low, asynchronous to clk.
REQ-006 col_select  output  4  keypad column drive, active-low, one-hot-low.
REQ-007 key_code  output  4  code of the last debounced key.
REQ-008 key_valid  output  1  one-cycle pulse when a new debounced press is accepted.
REQ-009 entry_value  output  10  binary value of the digits typed so far, 0..999, for live display.
REQ-010 number_out  output  10  committed operand, 0..999.
REQ-011 number_valid  output  1  number_out holds a committed operand not yet consumed.
REQ-012 number_ready  input  1  consumer accepts number_out.

Function
REQ-013 The block SHALL pass rows through a 2-flop synchronizer before any use; all row timing below is measured at the synchronizer output.
REQ-014 Key map (row r, column c, index 0 = LSB) SHALL be: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: * 0 # D. Codes: digits 0x0-0x9, A-D 0xA-0xD, * 0xE, # 0xF.
REQ-015 FSM states SHALL be S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE.
REQ-016 S_SCAN: col_select SHALL rotate 1110->1101->1011->0111->1110, each held SCAN_CYCLES cycles. Rows are sampled in the last cycle of each dwell. Any row low: latch column and row pattern, hold column, go to S_DEBOUNCE.
REQ-017 S_DEBOUNCE: a counter SHALL increment each cycle the rows equal the latched pattern. On mismatch, return to S_SCAN and advance to the next column. On reaching DEBOUNCE_CYCLES, pulse key_valid for one cycle with key_code updated in the same cycle, then go to S_PRESSED.
REQ-018 If several rows are low, the lowest-index low row SHALL define the key.
REQ-019 S_PRESSED: column held. All rows high: go to S_RELEASE with the counter cleared. No repeat key_valid while held.
REQ-020 S_RELEASE: all rows high for DEBOUNCE_CYCLES cycles: go to S_SCAN, starting at the next column. Any row low first: go back to S_PRESSED with no new key_valid.
REQ-021 Entry, applied the cycle after key_valid:
- Digit key: entry_value SHALL become entry_value*10+digit if fewer than 3 digits have been entered; otherwise the digit is ignored.
- '*': clear entry_value and the digit count.
- '#': see REQ-022.
- A-D: no effect on entry; still reported on key_code/key_valid.
REQ-022 '#' with digit count >0 and number_valid low SHALL load number_out with entry_value, set number_valid, and clear the entry. '#' with zero digits, or while number_valid is high, SHALL be ignored and the entry kept.
REQ-023 number_valid SHALL stay high and number_out stable until a cycle with number_valid and number_ready both high; number_valid clears after that edge.
REQ-024 If the commit and the ready handshake fall in the same cycle, the handshake SHALL complete first. The commit is then evaluated against the pre-edge number_valid (high), so '#' is ignored.
REQ-025 The maximum committed value SHALL be 999, so the downstream 12-bit adder never exceeds 1998.

Reset
REQ-026 In a cycle where reset is high, the block SHALL load state S_SCAN, col_select 1110, scan and debounce counters 0, key_code 0, key_valid 0, entry_value 0, digit count 0, number_out 0, number_valid 0, and clear the synchronizer flops.
REQ-027 Reset SHALL take priority over every other event, including mid-debounce and a pending number_valid. The pending operand is discarded.

Structure
REQ-028 Package keypad_pkg SHALL hold the state enum, the key code constants (KEY_STAR=0xE, KEY_HASH=0xF), and the operand width (10) and digit limit (3).
REQ-029 The synchronizer SHALL be a separate sub-module named sync_2ff, 4 bits wide, instantiated once.
REQ-030 The scan FSM and the entry/commit logic SHALL live in keypad_reader.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-031 Reset asserted then released, no keys -> col_select cycles 1110,1101,1011,0111 at 4-cycle dwell; all outputs 0.
REQ-032 Key '5' (row1 low while col 1101) held 20 cycles -> exactly one key_valid, key_code 0x5, entry_value 5, no repeat while held.
REQ-033 Row bounces low for 3 cycles only -> no key_valid, scan resumes at the next column.
REQ-034 Keys 9,9,9,9 then '#', number_ready 0 -> entry 999, fourth 9 ignored, number_valid 1, number_out 999 held. number_ready 1 -> number_valid 0 next cycle.
REQ-035 Keys 1,2 then '*' then 7,'#' -> entry 12, then 0, then 7; number_out 7. A second '#' with empty entry -> ignored.
REQ-036 Reset asserted during S_DEBOUNCE with number_valid 1 -> next cycle all outputs 0 and col_select 1110.
